// File: rtl/vic_reg_arbiter.sv
// VIC register-file port owner: writes a default image into all 32 nibbles after
// reset, then shares the single access port between requesters A and B (round-robin).
module vic_reg_arbiter #(
  parameter logic [127:0] INIT_VALUE  = 128'h0,
  parameter bit           INIT_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_a_req,
  input  logic       i_a_we,
  input  logic [4:0] i_a_addr,
  input  logic [3:0] i_a_wdata,
  output logic       o_a_ack,
  output logic [3:0] o_a_rdata,
  input  logic       i_b_req,
  input  logic       i_b_we,
  input  logic [4:0] i_b_addr,
  input  logic [3:0] i_b_wdata,
  output logic       o_b_ack,
  output logic [3:0] o_b_rdata,
  output logic [4:0] o_VIC_regaddr,
  output logic [3:0] o_VIC_data,
  output logic       o_VIC_we,
  output logic       o_VIC_re,
  input  logic [3:0] i_VIC_data,
  output logic       o_init_done
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACC, ST_ACK} state_t;

  state_t     r_state, w_state_next;
  logic [5:0] r_init_cnt, w_init_cnt_next;
  logic       r_ptr_b, w_ptr_b_next;
  logic       r_grant_b, w_grant_b_next;
  logic       r_rd, w_rd_next;
  logic [4:0] r_vic_addr, w_vic_addr_next;
  logic [3:0] r_vic_data, w_vic_data_next;
  logic       r_vic_we, w_vic_we_next;
  logic       r_vic_re, w_vic_re_next;
  logic       r_a_ack, w_a_ack_next;
  logic       r_b_ack, w_b_ack_next;
  logic [3:0] r_a_rdata, w_a_rdata_next;
  logic [3:0] r_b_rdata, w_b_rdata_next;
  logic       r_init_done, w_init_done_next;

  logic       w_any_req;
  logic       w_sel_b;
  logic       w_sel_we;
  logic [4:0] w_sel_addr;
  logic [3:0] w_sel_wdata;
  logic [6:0] w_init_bit;

  // B wins when it is the only requester, or on a tie when the pointer favours it
  assign w_any_req   = i_a_req | i_b_req;
  assign w_sel_b     = i_b_req & (~i_a_req | r_ptr_b);
  assign w_sel_we    = w_sel_b ? i_b_we    : i_a_we;
  assign w_sel_addr  = w_sel_b ? i_b_addr  : i_a_addr;
  assign w_sel_wdata = w_sel_b ? i_b_wdata : i_a_wdata;
  assign w_init_bit  = {r_init_cnt[4:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_ENABLE ? ST_INIT : ST_IDLE;
      r_init_cnt  <= 6'd0;
      r_ptr_b     <= 1'b0;
      r_grant_b   <= 1'b0;
      r_rd        <= 1'b0;
      r_vic_addr  <= 5'd0;
      r_vic_data  <= 4'd0;
      r_vic_we    <= 1'b0;
      r_vic_re    <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= 4'd0;
      r_b_rdata   <= 4'd0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_cnt  <= w_init_cnt_next;
      r_ptr_b     <= w_ptr_b_next;
      r_grant_b   <= w_grant_b_next;
      r_rd        <= w_rd_next;
      r_vic_addr  <= w_vic_addr_next;
      r_vic_data  <= w_vic_data_next;
      r_vic_we    <= w_vic_we_next;
      r_vic_re    <= w_vic_re_next;
      r_a_ack     <= w_a_ack_next;
      r_b_ack     <= w_b_ack_next;
      r_a_rdata   <= w_a_rdata_next;
      r_b_rdata   <= w_b_rdata_next;
      r_init_done <= w_init_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_init_cnt_next  = r_init_cnt;
    w_ptr_b_next     = r_ptr_b;
    w_grant_b_next   = r_grant_b;
    w_rd_next        = r_rd;
    w_vic_addr_next  = 5'd0;
    w_vic_data_next  = 4'd0;
    w_vic_we_next    = 1'b0;
    w_vic_re_next    = 1'b0;
    w_a_ack_next     = 1'b0;
    w_b_ack_next     = 1'b0;
    w_a_rdata_next   = r_a_rdata;
    w_b_rdata_next   = r_b_rdata;
    w_init_done_next = r_init_done;

    case (r_state)
      ST_INIT: begin
        w_init_done_next = 1'b0;
        // counter reaching 32 gives one quiet cycle after the last image write
        if (r_init_cnt[5]) begin
          w_state_next     = ST_IDLE;
          w_init_done_next = 1'b1;
        end else begin
          w_vic_we_next   = 1'b1;
          w_vic_addr_next = r_init_cnt[4:0];
          w_vic_data_next = INIT_VALUE[w_init_bit +: 4];
          w_init_cnt_next = r_init_cnt + 6'd1;
        end
      end
      ST_IDLE: begin
        w_init_done_next = 1'b1;
        if (w_any_req) begin
          w_state_next    = ST_ACC;
          w_grant_b_next  = w_sel_b;
          w_ptr_b_next    = ~w_sel_b;
          w_rd_next       = ~w_sel_we;
          w_vic_addr_next = w_sel_addr;
          w_vic_we_next   = w_sel_we;
          w_vic_re_next   = ~w_sel_we;
          w_vic_data_next = w_sel_we ? w_sel_wdata : 4'd0;
        end
      end
      ST_ACC: begin
        w_state_next = ST_ACK;
        if (r_grant_b) begin
          w_b_ack_next = 1'b1;
          if (r_rd) w_b_rdata_next = i_VIC_data;
        end else begin
          w_a_ack_next = 1'b1;
          if (r_rd) w_a_rdata_next = i_VIC_data;
        end
      end
      ST_ACK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_a_ack       = r_a_ack;
  assign o_a_rdata     = r_a_rdata;
  assign o_b_ack       = r_b_ack;
  assign o_b_rdata     = r_b_rdata;
  assign o_VIC_regaddr = r_vic_addr;
  assign o_VIC_data    = r_vic_data;
  assign o_VIC_we      = r_vic_we;
  assign o_VIC_re      = r_vic_re;
  assign o_init_done   = r_init_done;

endmodule

// File: tb/tb_vic_reg_arbiter.sv
// Randomised bench for vic_reg_arbiter: a register-file model on the port plus a
// transaction-level reference (3-cycle transactions, round-robin ties) checked each cycle.
module tb_vic_reg_arbiter;

  localparam logic [127:0] INIT_IMG = 128'hFEDCBA9876543210_0123456789ABCDEF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = 5'd0, b_addr = 5'd0;
  logic [3:0] a_wdata = 4'd0, b_wdata = 4'd0;
  logic       a_ack, b_ack, vic_we, vic_re, init_done;
  logic [3:0] a_rdata, b_rdata, vic_data, vic_rdata;
  logic [4:0] vic_addr;
  logic       d2_a_ack, d2_b_ack, d2_we, d2_re, d2_done;
  logic [3:0] d2_a_rdata, d2_b_rdata, d2_data;
  logic [4:0] d2_addr;

  logic [3:0] rf_mem [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vic_reg_arbiter #(.INIT_VALUE(INIT_IMG), .INIT_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata),
    .o_VIC_regaddr(vic_addr), .o_VIC_data(vic_data), .o_VIC_we(vic_we),
    .o_VIC_re(vic_re), .i_VIC_data(vic_rdata), .o_init_done(init_done)
  );

  vic_reg_arbiter #(.INIT_VALUE(INIT_IMG), .INIT_ENABLE(1'b0)) dut_noinit (
    .clk(clk), .rst(rst),
    .i_a_req(1'b0), .i_a_we(1'b0), .i_a_addr(5'd0), .i_a_wdata(4'd0),
    .o_a_ack(d2_a_ack), .o_a_rdata(d2_a_rdata),
    .i_b_req(1'b0), .i_b_we(1'b0), .i_b_addr(5'd0), .i_b_wdata(4'd0),
    .o_b_ack(d2_b_ack), .o_b_rdata(d2_b_rdata),
    .o_VIC_regaddr(d2_addr), .o_VIC_data(d2_data), .o_VIC_we(d2_we),
    .o_VIC_re(d2_re), .i_VIC_data(4'd0), .o_init_done(d2_done)
  );

  // register file: written by the port strobe, read combinationally
  assign vic_rdata = rf_mem[vic_addr];
  always @(posedge clk) if (vic_we) rf_mem[vic_addr] <= vic_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] init_nib(input int n);
    logic [127:0] v;
    v = INIT_IMG;
    return v[4*n +: 4];
  endfunction

  // ---------------- reference model / monitor ----------------
  int         cyc = 0;
  int         next_ok = 32'h3fffffff;
  int         ack_due = -1;
  int         last_srv = 1;
  int         init_idx = 0;
  int         m_side;
  bit         prev_rst = 1'b1;
  bit         init_phase = 1'b0;
  bit         ack_rd = 1'b0;
  logic [3:0] ack_val;
  logic [3:0] ref_mem [32];
  logic [3:0] exp_rdata [2];
  logic       s_a_req = 1'b0, s_b_req = 1'b0, s_a_we, s_b_we, m_we;
  logic [4:0] s_a_addr, s_b_addr, m_addr;
  logic [3:0] s_a_wd, s_b_wd, m_wd;
  logic [10:0] port;

  always @(negedge clk) begin
    cyc++;
    port = {vic_we, vic_re, vic_addr, vic_data};
    if (!rst) begin
      check_eq("noinit_done", 128'(d2_done), 128'(!prev_rst));
      check_eq("noinit_strobe", 128'({d2_we, d2_re}), 128'(0));
    end
    if (rst) begin
      prev_rst = 1'b1;
      ack_due = -1;
      init_phase = 1'b0;
      next_ok = 32'h3fffffff;
    end else if (prev_rst) begin
      prev_rst = 1'b0;
      check_eq("rst_port", 128'(port), 128'(0));
      check_eq("rst_ack", 128'({a_ack, b_ack}), 128'(0));
      check_eq("rst_rdata", 128'({a_rdata, b_rdata}), 128'(0));
      check_eq("rst_done", 128'(init_done), 128'(0));
      for (int n = 0; n < 32; n++) ref_mem[n] = init_nib(n);
      exp_rdata[0] = 4'd0;
      exp_rdata[1] = 4'd0;
      last_srv = 1;
      init_idx = 0;
      init_phase = 1'b1;
    end else if (init_phase) begin
      check_eq("init_port", 128'(port), 128'({2'b10, 5'(init_idx), init_nib(init_idx)}));
      check_eq("init_ack", 128'({a_ack, b_ack}), 128'(0));
      check_eq("init_done_low", 128'(init_done), 128'(0));
      init_idx++;
      if (init_idx == 32) begin
        init_phase = 1'b0;
        next_ok = cyc + 1;
      end
    end else begin
      check_eq("init_done", 128'(init_done), 128'(1));
      if (ack_due >= 0) begin
        if (ack_rd) exp_rdata[ack_due] = ack_val;
        check_eq("ack", 128'({a_ack, b_ack}), 128'(ack_due == 0 ? 2'b10 : 2'b01));
        ack_due = -1;
      end else begin
        check_eq("stray_ack", 128'({a_ack, b_ack}), 128'(0));
      end
      check_eq("a_rdata", 128'(a_rdata), 128'(exp_rdata[0]));
      check_eq("b_rdata", 128'(b_rdata), 128'(exp_rdata[1]));
      if ((cyc - 1 >= next_ok) && (s_a_req || s_b_req)) begin
        m_side = (s_a_req && s_b_req) ? 1 - last_srv : (s_a_req ? 0 : 1);
        last_srv = m_side;
        m_we   = m_side == 1 ? s_b_we   : s_a_we;
        m_addr = m_side == 1 ? s_b_addr : s_a_addr;
        m_wd   = m_side == 1 ? s_b_wd   : s_a_wd;
        check_eq("access_port", 128'(port), 128'({m_we, !m_we, m_addr, m_we ? m_wd : 4'd0}));
        ack_rd = !m_we;
        ack_val = ref_mem[m_addr];
        if (m_we) ref_mem[m_addr] = m_wd;
        ack_due = m_side;
        next_ok = cyc + 2;
      end else begin
        check_eq("quiet_port", 128'(port), 128'(0));
      end
    end
    s_a_req = a_req; s_a_we = a_we; s_a_addr = a_addr; s_a_wd = a_wdata;
    s_b_req = b_req; s_b_we = b_we; s_b_addr = b_addr; s_b_wd = b_wdata;
  end

  // ---------------- stimulus ----------------
  int unsigned p_a = 0, p_b = 0;
  bit hold_a = 1'b0, hold_b = 1'b0;

  task automatic rand_a();
    a_we = 1'($urandom_range(1)); a_addr = 5'($urandom_range(31)); a_wdata = 4'($urandom_range(15));
  endtask

  task automatic rand_b();
    b_we = 1'($urandom_range(1)); b_addr = 5'($urandom_range(31)); b_wdata = 4'($urandom_range(15));
  endtask

  // one clock: requesters drop (or renew, when holding) on ack, else maybe raise
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_req && a_ack) begin
      a_req = hold_a;
      if (hold_a) rand_a();
    end else if (!a_req && $urandom_range(99) < p_a) begin
      rand_a();
      a_req = 1'b1;
    end
    if (b_req && b_ack) begin
      b_req = hold_b;
      if (hold_b) rand_b();
    end else if (!b_req && $urandom_range(99) < p_b) begin
      rand_b();
      b_req = 1'b1;
    end
  endtask

  task automatic settle();
    p_a = 0; p_b = 0; hold_a = 1'b0; hold_b = 1'b0;
    repeat (12) tick();
  endtask

  task automatic xfer(input int side, input logic we, input logic [4:0] addr, input logic [3:0] wd);
    bit done;
    done = 1'b0;
    if (side == 0) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    else           begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = (side == 0) ? a_ack : b_ack;
    end
    check_eq("xfer_ack_seen", 128'(done), 128'(1));
  endtask

  logic [127:0] buf_v;
  bit           seen_a, seen_b, found;
  int           prev_side, last_k, n_acks;

  initial begin
    repeat (3) tick();

    // B requests throughout the init walk
    b_we = 1'b0; b_addr = 5'd7; b_req = 1'b1;
    rst = 1'b0;
    seen_b = 1'b0;
    for (int k = 0; k < 60 && !seen_b; k++) begin
      tick();
      if (b_ack) begin
        seen_b = 1'b1;
        check_eq("t4_ack_after_init", 128'(init_done), 128'(1));
        check_eq("t4_rdata", 128'(b_rdata), 128'(init_nib(7)));
      end
    end
    check_eq("t4_ack_seen", 128'(seen_b), 128'(1));
    for (int n = 0; n < 32; n++) buf_v[4*n +: 4] = rf_mem[n];
    check_eq("t1_image", buf_v, INIT_IMG);

    // simultaneous requests: A write then B read of the same register
    a_we = 1'b1; a_addr = 5'd3; a_wdata = 4'h1; a_req = 1'b1;
    b_we = 1'b0; b_addr = 5'd3; b_req = 1'b1;
    seen_a = 1'b0; seen_b = 1'b0;
    for (int k = 0; k < 20 && !seen_b; k++) begin
      tick();
      if (a_ack) seen_a = 1'b1;
      if (b_ack) begin
        seen_b = 1'b1;
        check_eq("t3_a_first", 128'(seen_a), 128'(1));
        check_eq("t3_b_rdata", 128'(b_rdata), 128'(4'h1));
      end
    end
    check_eq("t3_b_seen", 128'(seen_b), 128'(1));

    // both held: grants must alternate
    hold_a = 1'b1; hold_b = 1'b1;
    rand_a(); rand_b(); a_req = 1'b1; b_req = 1'b1;
    prev_side = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (a_ack || b_ack) begin
        if (prev_side >= 0) check_eq("t3_alternate", 128'(b_ack ? 1 : 0), 128'(1 - prev_side));
        prev_side = b_ack ? 1 : 0;
      end
    end
    settle();

    // single write then read back
    xfer(0, 1'b1, 5'd5, 4'hA);
    xfer(0, 1'b0, 5'd5, 4'h0);
    check_eq("t2_rdata", 128'(a_rdata), 128'(4'hA));

    // random traffic, then both sides held with random operations
    p_a = 35; p_b = 35;
    repeat (300) tick();
    hold_a = 1'b1; hold_b = 1'b1;
    repeat (60) tick();
    settle();

    // reset during the access cycle of an A write
    a_we = 1'b1; a_addr = 5'd9; a_wdata = ~init_nib(9); a_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = vic_we && (vic_addr == 5'd9);
    end
    check_eq("t5_acc_seen", 128'(found), 128'(1));
    rst = 1'b1; a_req = 1'b0;
    tick();
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      found = init_done;
    end
    check_eq("t5_reinit", 128'(found), 128'(1));
    xfer(0, 1'b0, 5'd9, 4'h0);
    check_eq("t5_overwritten", 128'(a_rdata), 128'(init_nib(9)));

    p_a = 50; p_b = 50;
    repeat (200) tick();
    settle();

    // B alone with a held request: one ack every 3 cycles
    hold_b = 1'b1; rand_b(); b_req = 1'b1;
    last_k = -1; n_acks = 0;
    for (int k = 0; k < 31; k++) begin
      tick();
      if (b_ack) begin
        if (last_k >= 0) check_eq("t6_gap", 128'(k - last_k), 128'(3));
        last_k = k;
        n_acks++;
      end
    end
    check_eq("t6_ack_count", 128'(n_acks >= 9), 128'(1));
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
